// File: rtl/reg_skid_buffer.sv
// reg_skid_buffer: two-entry elastic pipeline register.
// Fully registered valid/ready on both sides; main + skid.
module reg_skid_buffer #(
  parameter int DATAWIDTH = 8
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [DATAWIDTH-1:0] in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DATAWIDTH-1:0] out_data,
  output logic [1:0]           count
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t               state;
  state_t               state_nx;
  logic [DATAWIDTH-1:0] main_q;
  logic [DATAWIDTH-1:0] skid_q;
  logic                 accept;
  logic                 drain;
  logic                 ld_main;
  logic                 ld_skid;
  logic                 sel_skid;

  assign accept   = in_valid & in_ready;
  assign drain    = out_valid & out_ready;
  assign out_data = main_q;

  // State, datapath and registered handshake outputs.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state     <= EMPTY;
      main_q    <= '0;
      skid_q    <= '0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      count     <= 2'd0;
    end else begin
      state     <= state_nx;
      in_ready  <= (state_nx != FULL);
      out_valid <= (state_nx != EMPTY);
      count     <= state_nx;
      if (ld_main)
        main_q <= sel_skid ? skid_q : in_data;
      if (ld_skid)
        skid_q <= in_data;
    end
  end

  // Next-state decode from the handshake events.
  always_comb begin
    state_nx = state;
    unique case (state)
      EMPTY: begin
        if (accept)
          state_nx = BUSY;
      end
      BUSY: begin
        if (accept && !drain)
          state_nx = FULL;
        else if (drain && !accept)
          state_nx = EMPTY;
      end
      FULL: begin
        if (drain)
          state_nx = BUSY;
      end
      default: state_nx = EMPTY;
    endcase
  end

  // Register load enables; FULL refills main from skid.
  always_comb begin
    ld_main  = 1'b0;
    ld_skid  = 1'b0;
    sel_skid = 1'b0;
    unique case (1'b1)
      (state == EMPTY): ld_main = accept;
      (state == BUSY): begin
        ld_main = accept & drain;
        ld_skid = accept & ~drain;
      end
      (state == FULL): begin
        ld_main  = drain;
        sel_skid = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_reg_skid_buffer.sv
// tb_reg_skid_buffer: directed vectors for reg_skid_buffer.
// Inputs change and outputs are sampled 1ns after posedge.
module tb_reg_skid_buffer;

  logic       Clk;
  logic       Rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic [1:0] count;

  int n_vec;
  int n_bad;

  reg_skid_buffer #(.DATAWIDTH(8)) dut (
    .Clk       (Clk),
    .Rst       (Rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .count     (count)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic st(input string tag,
                    input logic       v,
                    input logic [7:0] d,
                    input logic [1:0] c,
                    input logic       r);
    chk({tag, ".ov"}, out_valid, v);
    if (v)
      chk({tag, ".od"}, out_data, d);
    chk({tag, ".cnt"}, count, c);
    chk({tag, ".ir"}, in_ready, r);
  endtask

  initial begin
    n_vec     = 0;
    n_bad     = 0;
    Rst       = 1'b0;
    in_valid  = 1'b1;
    in_data   = 8'hAA;
    out_ready = 1'b0;

    // 1: reset held, then released between edges
    for (int i = 0; i < 3; i++) begin
      step();
      st("rst", 1'b0, 8'h00, 2'd0, 1'b0);
      chk("rst.od", out_data, 8'h00);
    end
    Rst = 1'b1;
    step();
    st("rel", 1'b0, 8'h00, 2'd0, 1'b1);

    // 2: streaming at full rate
    in_valid = 1'b0;
    step();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      in_data = 8'(i);
      step();
      st("strm", 1'b1, 8'(i), 2'd1, 1'b1);
    end
    in_valid = 1'b0;
    step();
    st("strm_end", 1'b0, 8'h00, 2'd0, 1'b1);

    // 3: backpressure fill
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 8'h11;
    step();
    st("bp1", 1'b1, 8'h11, 2'd1, 1'b1);
    in_data = 8'h22;
    step();
    st("bp2", 1'b1, 8'h11, 2'd2, 1'b0);
    in_data = 8'h33;
    step();
    st("bp3", 1'b1, 8'h11, 2'd2, 1'b0);

    // 4: drain from FULL with 33 still offered
    out_ready = 1'b1;
    step();
    st("dr1", 1'b1, 8'h22, 2'd1, 1'b1);
    step();
    st("dr2", 1'b1, 8'h33, 2'd1, 1'b1);
    in_valid = 1'b0;
    step();
    st("dr3", 1'b0, 8'h00, 2'd0, 1'b1);

    // 5: simultaneous accept and drain in BUSY
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 8'h44;
    step();
    st("sim1", 1'b1, 8'h44, 2'd1, 1'b1);
    in_data   = 8'h55;
    out_ready = 1'b1;
    step();
    st("sim2", 1'b1, 8'h55, 2'd1, 1'b1);
    in_valid = 1'b0;
    step();
    st("sim3", 1'b0, 8'h00, 2'd0, 1'b1);

    // 6: asynchronous reset while FULL
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 8'h66;
    step();
    in_data = 8'h77;
    step();
    st("mid_full", 1'b1, 8'h66, 2'd2, 1'b0);
    in_valid = 1'b0;
    #2;
    Rst = 1'b0;
    #1;
    st("mid_rst", 1'b0, 8'h00, 2'd0, 1'b0);
    chk("mid_rst.od", out_data, 8'h00);
    #1;
    Rst = 1'b1;
    step();
    st("mid_rel", 1'b0, 8'h00, 2'd0, 1'b1);
    in_valid  = 1'b1;
    in_data   = 8'h88;
    out_ready = 1'b1;
    step();
    st("post1", 1'b1, 8'h88, 2'd1, 1'b1);
    in_valid = 1'b0;
    step();
    st("post2", 1'b0, 8'h00, 2'd0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

endmodule
